// File: rtl/avmm_reader_pkg.sv
// Shared types and helpers for the Avalon-MM window reader.
package avmm_reader_pkg;

    // Controller states: waiting for a command, issuing reads, waiting for the stream to empty.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    // The slave is always read a full 32-bit word at a time.
    localparam logic [3:0] BYTEENABLE_ALL = 4'hF;

    // Smallest n with 2**n >= value, usable in parameter expressions.
    function automatic int clog2_f(input int value);
        int res;
        res = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                res = i + 1;
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/avmm_reader_fifo.sv
// Return-data buffer: synchronous FIFO with registered storage and an occupancy count.
module avmm_reader_fifo
    import avmm_reader_pkg::*;
#(
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 8,
    localparam int PTR_W  = clog2_f(DEPTH),
    localparam int CNT_W  = PTR_W + 1
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_data,
    output logic [CNT_W-1:0]  o_count,
    output logic              o_empty
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              w_do_push;
    logic              w_do_pop;

    // Full/empty guards keep the pointers coherent even if a caller misbehaves.
    assign w_do_push = i_push & (r_count != CNT_W'(DEPTH));
    assign w_do_pop  = i_pop  & (r_count != {CNT_W{1'b0}});

    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_empty = (r_count == {CNT_W{1'b0}});

    // Storage write; contents cleared on reset so no stale word can ever be presented.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= {DATA_W{1'b0}};
            end
        end else if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end else begin
            r_mem[r_wr_ptr] <= r_mem[r_wr_ptr];
        end
    end

    // Pointer and occupancy tracking; simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_count  <= {CNT_W{1'b0}};
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end else begin
                r_wr_ptr <= r_wr_ptr;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end else begin
                r_rd_ptr <= r_rd_ptr;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/avmm_window_reader.sv
// Avalon-MM read master streaming a contiguous run of words out as ready/valid data.
// Reads are credit-limited against the return FIFO so pipelined slaves cannot overflow it.
module avmm_window_reader
    import avmm_reader_pkg::*;
#(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 32,
    parameter int LEN_W      = 11,
    parameter int FIFO_DEPTH = 8
)(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    output logic [3:0]        avm_byteenable,
    input  logic              avm_waitrequest,
    input  logic [DATA_W-1:0] avm_readdata,
    input  logic              avm_readdatavalid,
    output logic              src_valid,
    input  logic              src_ready,
    output logic [DATA_W-1:0] src_data,
    output logic              src_last,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int CNT_W = clog2_f(FIFO_DEPTH) + 1;

    state_e            r_state;
    state_e            w_state_next;
    logic              r_cmd_ready;
    logic              r_busy;
    logic              r_done;
    logic              r_err;
    logic [ADDR_W-1:0] r_addr;
    logic [LEN_W-1:0]  r_issue_cnt;
    logic [LEN_W-1:0]  r_deliv_cnt;
    logic [CNT_W-1:0]  r_pending;

    logic              w_cmd_fire;
    logic              w_len_nz;
    logic [CNT_W-1:0]  w_outstanding;
    logic              w_credit;
    logic              w_avm_read;
    logic              w_accept;
    logic              w_push;
    logic              w_stray;
    logic              w_pop;
    logic              w_last_pop;
    logic [DATA_W-1:0] w_fifo_data;
    logic [CNT_W-1:0]  w_fifo_count;
    logic              w_fifo_empty;

    // cmd_ready is only ever high in IDLE, so it doubles as the "in IDLE" qualifier.
    assign w_cmd_fire = cmd_valid & r_cmd_ready;
    assign w_len_nz   = (cmd_len != {LEN_W{1'b0}});

    // Words in flight plus words buffered never exceed the FIFO depth.
    assign w_outstanding = r_pending + w_fifo_count;
    assign w_credit      = (w_outstanding < CNT_W'(FIFO_DEPTH));

    // Decoded from registers only, so it cannot drop while the slave stalls:
    // a stall freezes issue_cnt/pending and pops can only add credit.
    assign w_avm_read = (r_state == ST_ISSUE) & (r_issue_cnt != {LEN_W{1'b0}}) & w_credit;
    assign w_accept   = w_avm_read & ~avm_waitrequest;

    assign w_push  = avm_readdatavalid & (r_pending != {CNT_W{1'b0}});
    assign w_stray = avm_readdatavalid & (r_pending == {CNT_W{1'b0}});

    assign src_valid  = ~w_fifo_empty;
    assign src_data   = w_fifo_data;
    assign src_last   = src_valid & (r_deliv_cnt == LEN_W'(1));
    assign w_pop      = src_valid & src_ready;
    assign w_last_pop = w_pop & (r_deliv_cnt == LEN_W'(1));

    assign cmd_ready      = r_cmd_ready;
    assign busy           = r_busy;
    assign done           = r_done;
    assign err            = r_err;
    assign avm_address    = r_addr;
    assign avm_read       = w_avm_read;
    assign avm_byteenable = BYTEENABLE_ALL;

    avmm_reader_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset_n),
        .i_push  (w_push),
        .i_data  (avm_readdata),
        .i_pop   (w_pop),
        .o_data  (w_fifo_data),
        .o_count (w_fifo_count),
        .o_empty (w_fifo_empty)
    );

    // Next-state selection for the run controller.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_cmd_fire && w_len_nz) begin
                    w_state_next = ST_ISSUE;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (w_accept && (r_issue_cnt == LEN_W'(1))) begin
                    w_state_next = ST_DRAIN;
                end else begin
                    w_state_next = ST_ISSUE;
                end
            end
            ST_DRAIN: begin
                if (w_last_pop) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_state_next = ST_DRAIN;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // State register plus the status flags derived from where the controller goes next.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_cmd_ready <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_cmd_ready <= (w_state_next == ST_IDLE);
            r_busy      <= (w_state_next != ST_IDLE);
            r_done      <= (w_cmd_fire & ~w_len_nz) | w_last_pop;
        end
    end

    // Address and issue/delivery countdowns; the address wraps naturally at the top of memory.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_addr      <= {ADDR_W{1'b0}};
            r_issue_cnt <= {LEN_W{1'b0}};
            r_deliv_cnt <= {LEN_W{1'b0}};
        end else if (w_cmd_fire && w_len_nz) begin
            r_addr      <= cmd_addr;
            r_issue_cnt <= cmd_len;
            r_deliv_cnt <= cmd_len;
        end else begin
            if (w_accept) begin
                r_addr      <= r_addr + ADDR_W'(1);
                r_issue_cnt <= r_issue_cnt - LEN_W'(1);
            end else begin
                r_addr      <= r_addr;
                r_issue_cnt <= r_issue_cnt;
            end
            if (w_pop) begin
                r_deliv_cnt <= r_deliv_cnt - LEN_W'(1);
            end else begin
                r_deliv_cnt <= r_deliv_cnt;
            end
        end
    end

    // Reads in flight: up on accepted request, down on each matched return.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pending <= {CNT_W{1'b0}};
        end else begin
            case ({w_accept, w_push})
                2'b10:   r_pending <= r_pending + CNT_W'(1);
                2'b01:   r_pending <= r_pending - CNT_W'(1);
                default: r_pending <= r_pending;
            endcase
        end
    end

    // Sticky flag for return data nobody asked for; a new run starts with it clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_err <= 1'b0;
        end else if (w_stray) begin
            r_err <= 1'b1;
        end else if (w_cmd_fire && w_len_nz) begin
            r_err <= 1'b0;
        end else begin
            r_err <= r_err;
        end
    end

endmodule

// File: tb/tb_avmm_window_reader.sv
// Bench for avmm_window_reader: memory-slave model, scoreboard queues, table of runs
// plus hand-written sequences for zero length, backpressure and reset mid-run.
module tb_avmm_window_reader;

    localparam int ADDR_W     = 10;
    localparam int DATA_W     = 32;
    localparam int LEN_W      = 11;
    localparam int FIFO_DEPTH = 8;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_addr = 10'h000;
    logic [LEN_W-1:0]  cmd_len = 11'd0;
    logic [ADDR_W-1:0] avm_address;
    logic              avm_read;
    logic [3:0]        avm_byteenable;
    logic              avm_waitrequest;
    logic [DATA_W-1:0] avm_readdata;
    logic              avm_readdatavalid;
    logic              src_valid;
    logic              src_ready;
    logic [DATA_W-1:0] src_data;
    logic              src_last;
    logic              busy;
    logic              done;
    logic              err;

    always #5 clk = ~clk;

    avmm_window_reader #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .avm_address(avm_address), .avm_read(avm_read), .avm_byteenable(avm_byteenable),
        .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
        .avm_readdatavalid(avm_readdatavalid),
        .src_valid(src_valid), .src_ready(src_ready), .src_data(src_data), .src_last(src_last),
        .busy(busy), .done(done), .err(err)
    );

    typedef struct {
        logic [31:0] data;
        logic        last;
    } exp_word_t;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        int                len;
        int                stall_idx;
        int                stall_cyc;
        bit                rand_ready;
        logic [ADDR_W-1:0] exp_end;
        int                exp_cyc;
    } vec_t;

    exp_word_t         q_data[$];
    logic [ADDR_W-1:0] q_addr[$];
    vec_t              vecs[6];

    int n_checks = 0;
    int n_err    = 0;
    int n_accept = 0;
    int n_done   = 0;
    int req_idx  = 0;
    int stall_idx = -1;
    int stall_cyc = 0;
    int stall_left = 0;
    bit rand_ready = 1'b0;
    bit ready_level = 1'b1;
    bit hold_returns = 1'b0;
    bit inject_rdv = 1'b0;
    bit zlen_ok = 1'b0;
    bit exp_done_next = 1'b0;

    function automatic logic [31:0] mem_word(input logic [ADDR_W-1:0] a);
        return {6'h2B, a, 6'h15, a};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Slave model, stream sink and scoreboard, all evaluated on the falling edge.
    initial begin : slave_sink
        bit                ret_pend;
        logic [ADDR_W-1:0] ret_addr;
        logic [ADDR_W-1:0] held_addr;
        bit                in_stall;
        exp_word_t         e;
        ret_pend = 1'b0; in_stall = 1'b0; ret_addr = 10'h000; held_addr = 10'h000;
        avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0; avm_readdata = 32'h0; src_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                ret_pend = 1'b0; in_stall = 1'b0;
                avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0; src_ready = 1'b0;
            end else begin
                // return path: one-cycle read latency
                if (ret_pend && !hold_returns) begin
                    avm_readdatavalid = 1'b1; avm_readdata = mem_word(ret_addr);
                end else if (inject_rdv) begin
                    avm_readdatavalid = 1'b1; avm_readdata = 32'hDEAD_BEEF; inject_rdv = 1'b0;
                end else begin
                    avm_readdatavalid = 1'b0;
                end
                ret_pend = 1'b0;
                // completion pulse
                if (exp_done_next) begin
                    chk("done_pulse", 32'(done), 32'd1);
                    chk("cmd_ready_at_done", 32'(cmd_ready), 32'd1);
                    exp_done_next = 1'b0;
                end else if (done && !zlen_ok) begin
                    chk("spurious_done", 32'(done), 32'd0);
                end
                if (done) n_done++;
                // stream side
                src_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_level;
                if (src_valid && src_ready) begin
                    if (q_data.size() == 0) begin
                        chk("extra_word", 32'(src_data), 32'hFFFF_FFFF);
                    end else begin
                        e = q_data.pop_front();
                        chk("src_data", src_data, e.data);
                        chk("src_last", 32'(src_last), 32'(e.last));
                        if (e.last) exp_done_next = 1'b1;
                    end
                end
                // request side
                if (in_stall && !avm_read) chk("read_held", 32'(avm_read), 32'd1);
                avm_waitrequest = 1'b0;
                if (avm_read) begin
                    if (req_idx == stall_idx && stall_left > 0) begin
                        if (in_stall) chk("addr_held", 32'(avm_address), 32'(held_addr));
                        in_stall = 1'b1; held_addr = avm_address;
                        avm_waitrequest = 1'b1; stall_left--;
                    end else begin
                        if (in_stall) chk("addr_held", 32'(avm_address), 32'(held_addr));
                        in_stall = 1'b0;
                        if (q_addr.size() == 0) chk("extra_read", 32'(avm_address), 32'hFFFF_FFFF);
                        else chk("rd_addr", 32'(avm_address), 32'(q_addr.pop_front()));
                        ret_pend = 1'b1; ret_addr = avm_address;
                        req_idx++; n_accept++;
                    end
                end
            end
        end
    end

    task automatic start_cmd(input logic [ADDR_W-1:0] a, input int len);
        int guard;
        exp_word_t ew;
        logic [ADDR_W-1:0] wa;
        guard = 0;
        while (!cmd_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        chk("cmd_ready_wait", 32'(cmd_ready), 32'd1);
        for (int i = 0; i < len; i++) begin
            wa = a + ADDR_W'(i);
            q_addr.push_back(wa);
            ew.data = mem_word(wa);
            ew.last = (i == len - 1);
            q_data.push_back(ew);
        end
        req_idx   = 0;
        cmd_addr  = a;
        cmd_len   = LEN_W'(len);
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!done && cyc < 3000);
        chk("done_seen", 32'(done), 32'd1);
    endtask

    initial begin : watchdog
        #1ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Main sequence.
    initial begin : main
        int cyc;
        int acc0;
        int done0;
        int g;

        vecs[0] = '{10'h010,  4, -1, 0, 1'b0, 10'h014,  6};
        vecs[1] = '{10'h3FE,  4, -1, 0, 1'b0, 10'h002,  6};
        vecs[2] = '{10'h100,  6,  1, 3, 1'b0, 10'h106,  0};
        vecs[3] = '{10'h3F0, 16,  3, 2, 1'b1, 10'h000,  0};
        vecs[4] = '{10'h1F8,  9, -1, 0, 1'b0, 10'h201, 11};
        vecs[5] = '{10'h3FF,  1, -1, 0, 1'b0, 10'h000,  3};

        // reset values
        #12;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst_avm_read", 32'(avm_read), 32'd0);
        chk("rst_avm_address", 32'(avm_address), 32'd0);
        chk("rst_src_valid", 32'(src_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("byteenable", 32'(avm_byteenable), 32'hF);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("cmd_ready_after_rst", 32'(cmd_ready), 32'd1);

        // table-driven runs
        for (int v = 0; v < 6; v++) begin
            rand_ready  = vecs[v].rand_ready;
            ready_level = 1'b1;
            stall_idx   = vecs[v].stall_idx;
            stall_cyc   = vecs[v].stall_cyc;
            stall_left  = vecs[v].stall_cyc;
            start_cmd(vecs[v].addr, vecs[v].len);
            wait_done(cyc);
            rand_ready = 1'b0;
            if (vecs[v].exp_cyc != 0) chk("run_latency", 32'(cyc), 32'(vecs[v].exp_cyc));
            chk("end_addr", 32'(avm_address), 32'(vecs[v].exp_end));
            chk("busy_at_done", 32'(busy), 32'd0);
            chk("data_sb_empty", 32'(q_data.size()), 32'd0);
            chk("addr_sb_empty", 32'(q_addr.size()), 32'd0);
            chk("err_clear", 32'(err), 32'd0);
        end
        stall_idx = -1;

        // zero-length command
        acc0 = n_accept; done0 = n_done; zlen_ok = 1'b1;
        start_cmd(10'h055, 0);
        chk("zlen_done", 32'(done), 32'd1);
        chk("zlen_busy", 32'(busy), 32'd0);
        chk("zlen_read", 32'(avm_read), 32'd0);
        repeat (3) @(negedge clk);
        zlen_ok = 1'b0;
        chk("zlen_done_once", 32'(n_done - done0), 32'd1);
        chk("zlen_no_reads", 32'(n_accept - acc0), 32'd0);
        chk("zlen_ready", 32'(cmd_ready), 32'd1);

        // sink stalled: only FIFO_DEPTH reads may be issued
        ready_level = 1'b0;
        acc0 = n_accept;
        start_cmd(10'h040, 20);
        repeat (40) @(negedge clk);
        chk("bp_reads", 32'(n_accept - acc0), 32'(FIFO_DEPTH));
        chk("bp_read_low", 32'(avm_read), 32'd0);
        chk("bp_src_valid", 32'(src_valid), 32'd1);
        chk("bp_busy", 32'(busy), 32'd1);
        ready_level = 1'b1;
        wait_done(cyc);
        chk("bp_sb_empty", 32'(q_data.size()), 32'd0);
        chk("bp_end_addr", 32'(avm_address), 32'h054);

        // reset with reads outstanding
        hold_returns = 1'b1;
        acc0 = n_accept;
        start_cmd(10'h080, 8);
        g = 0;
        while ((n_accept - acc0) < 3 && g < 100) begin
            @(posedge clk);
            g++;
        end
        chk("mid_reads", 32'(n_accept - acc0), 32'd3);
        #2;
        reset_n = 1'b0;
        #1;
        q_addr.delete(); q_data.delete(); exp_done_next = 1'b0;
        chk("mr_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("mr_avm_read", 32'(avm_read), 32'd0);
        chk("mr_avm_address", 32'(avm_address), 32'd0);
        chk("mr_src_valid", 32'(src_valid), 32'd0);
        chk("mr_src_last", 32'(src_last), 32'd0);
        chk("mr_busy", 32'(busy), 32'd0);
        chk("mr_done", 32'(done), 32'd0);
        chk("mr_err", 32'(err), 32'd0);
        chk("mr_byteenable", 32'(avm_byteenable), 32'hF);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("mr_ready_after", 32'(cmd_ready), 32'd1);
        hold_returns = 1'b0;
        inject_rdv = 1'b1;
        repeat (3) @(negedge clk);
        chk("stray_err", 32'(err), 32'd1);
        chk("stray_no_stream", 32'(src_valid), 32'd0);
        chk("stray_idle", 32'(busy), 32'd0);

        // a new run clears the sticky error
        start_cmd(10'h300, 2);
        chk("err_cleared", 32'(err), 32'd0);
        wait_done(cyc);
        chk("post_sb_empty", 32'(q_data.size()), 32'd0);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
